// File: rtl/jk_cmd_debouncer.sv
// Button front end for the JK flip-flop: synchronizes and debounces three
// raw buttons and emits one registered j/k command pulse per clean press.

module jk_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

    logic       sync1;
    logic       sync2;
    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Debounce state and stability counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; a full count is accepted before looking at s again,
    // so exactly DEBOUNCE_CYCLES high samples make a press.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press    = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync2) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = 8'd1;
                end
            end
            PRESS_WAIT: begin
                if (cnt >= LIMIT) begin
                    state_nx = HELD;
                    cnt_nx   = 8'd0;
                    press    = 1'b1;
                end else if (sync2) begin
                    cnt_nx = cnt + 8'd1;
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end
            end
            HELD: begin
                if (!sync2) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = 8'd1;
                end
            end
            RELEASE_WAIT: begin
                if (cnt >= LIMIT) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end else if (!sync2) begin
                    cnt_nx = cnt + 8'd1;
                end else begin
                    state_nx = HELD;
                    cnt_nx   = 8'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

endmodule

module jk_cmd_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_clr,
    input  logic btn_tog,
    output logic j,
    output logic k,
    output logic cmd_err
);

    logic p_set;
    logic p_clr;
    logic p_tog;
    logic multi;

    jk_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set (
        .clock(clock),
        .reset(reset),
        .btn  (btn_set),
        .press(p_set)
    );

    jk_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr (
        .clock(clock),
        .reset(reset),
        .btn  (btn_clr),
        .press(p_clr)
    );

    jk_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_tog (
        .clock(clock),
        .reset(reset),
        .btn  (btn_tog),
        .press(p_tog)
    );

    assign multi = (p_set & p_clr) | (p_set & p_tog) | (p_clr & p_tog);

    // Encode press events into a one-cycle command; collisions are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            j       <= 1'b0;
            k       <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            j       <= ~multi & (p_set | p_tog);
            k       <= ~multi & (p_clr | p_tog);
            cmd_err <= multi;
        end
    end

endmodule
